// File: rtl/ast_video_pkg.sv
// ast_video_pkg: shared Avalon-ST video packet type codes, parser states and control-packet layout
package ast_video_pkg;
  localparam logic [3:0] PKT_CTRL = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam int CTRL_NIBBLES = 9;
  localparam int FIELD_BIT = 2;
  typedef enum logic [1:0] {IDLE, CTRL, VIDEO, DRAIN} parser_state_t;
endpackage

// File: rtl/ast_video_parser_if.sv
// ast_video_parser_if: Avalon-ST sink plus tagged pixel source bundle
// slave modport = parser side (consumes din_*, produces pix_*); master modport = the surrounding fabric
interface ast_video_parser_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] din_data;
  logic din_startofpacket, din_endofpacket, din_valid, din_ready;
  logic [DATA_WIDTH-1:0] pix_data;
  logic [11:0] pix_x, pix_y;
  logic pix_sof, pix_eol, pix_field, pix_valid, pix_ready;
  modport slave(
    input din_data, din_startofpacket, din_endofpacket, din_valid, pix_ready,
    output din_ready, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_field, pix_valid
  );
  modport master(
    output din_data, din_startofpacket, din_endofpacket, din_valid, pix_ready,
    input din_ready, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_field, pix_valid
  );
endinterface

// File: rtl/ast_out_reg.sv
// ast_out_reg: one-deep valid/ready pixel output register
// ports: clock, reset (sync, active-low), load + pixel fields in, ready in, valid + registered fields out
module ast_out_reg #(parameter int DATA_WIDTH = 8) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [11:0]           x,
  input  logic [11:0]           y,
  input  logic                  sof,
  input  logic                  eol,
  input  logic                  field,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [11:0]           q_x,
  output logic [11:0]           q_y,
  output logic                  q_sof,
  output logic                  q_eol,
  output logic                  q_field
);
  always_ff @(posedge clock)
    if (!reset) begin
      valid <= 1'b0;
      q_data <= '0;
      q_x <= '0;
      q_y <= '0;
      q_sof <= 1'b0;
      q_eol <= 1'b0;
      q_field <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q_data <= data;
      q_x <= x;
      q_y <= y;
      q_sof <= sof;
      q_eol <= eol;
      q_field <= field;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/ast_video_parser.sv
// ast_video_parser: Avalon-ST video sink decoding control packets and unpacking video packets into tagged pixels
// ports: clock, reset (sync, active-low), bus (ast_video_parser_if.slave: din_* sink, pix_* source),
//        cfg_width/cfg_height/cfg_valid (committed config), err_pulse (one cycle per packet error)
// AST_PARSER_STATS_EN adds saturating stat_fields (clean video packets) and stat_errors (err_pulse count)
module ast_video_parser import ast_video_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH = 640,
  parameter int MAX_HEIGHT = 240
) (
  input  logic clock,
  input  logic reset,
  ast_video_parser_if.slave bus,
  output logic [11:0] cfg_width,
  output logic [11:0] cfg_height,
  output logic cfg_valid,
  output logic err_pulse
`ifdef AST_PARSER_STATS_EN
  ,
  output logic [15:0] stat_fields,
  output logic [15:0] stat_errors
`endif
);
  parser_state_t state, state_nx;
  logic [3:0] n, n_nx, typ;
  logic [15:0] w_sh, h_sh, w_nx, h_nx;
  logic il, il_nx, field, vfield, done, ovf;
  logic [11:0] vw, vh, x, y;
  logic acc, sop, eop, nib, commit, eol, last, pix_load, body;
  logic hdr_err, ctrl_err, vid_err, good;

  assign bus.din_ready = ~bus.pix_valid | bus.pix_ready;
  assign acc = bus.din_valid & bus.din_ready;
  assign sop = acc & bus.din_startofpacket;
  assign body = acc & ~bus.din_startofpacket;
  assign eop = bus.din_endofpacket;
  assign typ = bus.din_data[3:0];

  // control payload: 4 width nibbles, 4 height nibbles, then the interlace nibble, all MSB first
  assign nib = body & (state == CTRL) & (n < 4'(CTRL_NIBBLES));
  assign n_nx = nib ? n + 4'd1 : n;
  assign w_nx = nib & (n < 4'd4) ? {w_sh[11:0], typ} : w_sh;
  assign h_nx = nib & (n >= 4'd4) & (n < 4'd8) ? {h_sh[11:0], typ} : h_sh;
  assign il_nx = nib & (n == 4'd8) ? typ[FIELD_BIT] : il;
  assign commit = body & eop & (state == CTRL) & (n_nx == 4'(CTRL_NIBBLES)) &
                  (w_nx != '0) & (w_nx <= 16'(MAX_WIDTH)) & (h_nx != '0) & (h_nx <= 16'(MAX_HEIGHT));

  assign eol = x == vw - 12'd1;
  assign last = eol & (y == vh - 12'd1);
  assign pix_load = body & (state == VIDEO) & ~done;

  // a new SOP always restarts parsing, so any packet still open is reported as aborted
  assign hdr_err = sop & ((state != IDLE) | ((typ == PKT_CTRL) & eop) | ((typ == PKT_VIDEO) & (eop | ~cfg_valid)));
  assign ctrl_err = body & eop & (state == CTRL) & ~commit;
  assign vid_err = body & (state == VIDEO) & (done ? ~ovf : eop & ~last);
  assign good = body & eop & (state == VIDEO) & ~done & last;

  assign state_nx = sop ? (eop ? IDLE : typ == PKT_CTRL ? CTRL : (typ == PKT_VIDEO) & cfg_valid ? VIDEO : DRAIN) :
                    acc & eop ? IDLE : state;

  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      n <= '0;
      w_sh <= '0;
      h_sh <= '0;
      il <= 1'b0;
      field <= 1'b0;
      vfield <= 1'b0;
      vw <= '0;
      vh <= '0;
      x <= '0;
      y <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      cfg_width <= '0;
      cfg_height <= '0;
      cfg_valid <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      err_pulse <= hdr_err | ctrl_err | vid_err;
      n <= sop ? '0 : n_nx;
      w_sh <= w_nx;
      h_sh <= h_nx;
      il <= il_nx;
      if (commit) begin
        cfg_width <= w_nx[11:0];
        cfg_height <= h_nx[11:0];
        cfg_valid <= 1'b1;
        field <= il_nx;
      end
      if (sop) begin
        vw <= cfg_width;
        vh <= cfg_height;
        vfield <= field;
        x <= '0;
        y <= '0;
        done <= 1'b0;
        ovf <= 1'b0;
      end else if (pix_load) begin
        x <= eol ? '0 : x + 12'd1;
        y <= eol ? y + 12'd1 : y;
        done <= last;
      end else if (vid_err) ovf <= 1'b1;
    end

  ast_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clock(clock),
    .reset(reset),
    .load(pix_load),
    .data(bus.din_data),
    .x(x),
    .y(y),
    .sof((x == '0) & (y == '0)),
    .eol(eol),
    .field(vfield),
    .ready(bus.pix_ready),
    .valid(bus.pix_valid),
    .q_data(bus.pix_data),
    .q_x(bus.pix_x),
    .q_y(bus.pix_y),
    .q_sof(bus.pix_sof),
    .q_eol(bus.pix_eol),
    .q_field(bus.pix_field)
  );

`ifdef AST_PARSER_STATS_EN
  always_ff @(posedge clock)
    if (!reset) begin
      stat_fields <= '0;
      stat_errors <= '0;
    end else begin
      if (good && stat_fields != '1) stat_fields <= stat_fields + 16'd1;
      if (err_pulse && stat_errors != '1) stat_errors <= stat_errors + 16'd1;
    end
`else
  logic unused_good;
  assign unused_good = good;
`endif
endmodule

// File: tb/tb_ast_video_parser.sv
// tb_ast_video_parser: directed self-checking bench for ast_video_parser
module tb_ast_video_parser;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [11:0] cfg_width, cfg_height;
  logic cfg_valid, err_pulse;
`ifdef AST_PARSER_STATS_EN
  logic [15:0] stat_fields, stat_errors;
`endif
  ast_video_parser_if #(.DATA_WIDTH(8)) vif();

  ast_video_parser #(.DATA_WIDTH(8), .MAX_WIDTH(640), .MAX_HEIGHT(240)) dut (
    .clock(clock),
    .reset(reset),
    .bus(vif),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .cfg_valid(cfg_valid),
    .err_pulse(err_pulse)
`ifdef AST_PARSER_STATS_EN
    ,
    .stat_fields(stat_fields),
    .stat_errors(stat_errors)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, errs = 0, rdy_viol = 0;
  bit tog = 1'b0;
  logic [34:0] got[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (err_pulse) errs++;
    if (vif.pix_valid && vif.pix_ready)
      got.push_back({vif.pix_field, vif.pix_eol, vif.pix_sof, vif.pix_y, vif.pix_x, vif.pix_data});
    if (vif.pix_valid && !vif.pix_ready && vif.din_ready) rdy_viol++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    vif.pix_ready = tog ? ~vif.pix_ready : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic beat(input logic [7:0] d, input bit s, input bit e);
    int t = 0;
    vif.din_data = d;
    vif.din_startofpacket = s;
    vif.din_endofpacket = e;
    vif.din_valid = 1'b1;
    @(negedge clock);
    while (!vif.din_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("beat_timeout", t, 0);
    @(posedge clock);
    #1;
    vif.din_valid = 1'b0;
  endtask

  task automatic settle(input int c);
    repeat (c) @(posedge clock);
    #1;
  endtask

  task automatic ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    beat(8'h0F, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) beat({4'h5, w[i*4+:4]}, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) beat({4'h5, h[i*4+:4]}, 1'b0, 1'b0);
    beat({4'h5, il}, 1'b0, 1'b1);
  endtask

  task automatic video(input int npix);
    beat(8'h00, 1'b1, npix == 0);
    for (int k = 0; k < npix; k++) beat(8'(k * 7 + 3), 1'b0, k == npix - 1);
  endtask

  task automatic expect_pix(input string tag, input int n, input int w, input bit f);
    int bad = 0;
    check({tag, "_count"}, got.size(), n);
    foreach (got[k])
      if (got[k] !== {f, 12'(k % w) == 12'(w - 1), k == 0, 12'(k / w), 12'(k % w), 8'(k * 7 + 3)}) bad++;
    check({tag, "_pixels"}, bad, 0);
    got.delete();
  endtask

  initial begin
    vif.din_valid = 1'b0;
    vif.din_data = '0;
    vif.din_startofpacket = 1'b0;
    vif.din_endofpacket = 1'b0;
    vif.pix_ready = 1'b1;
    settle(2);
    check("rst_pix_valid", vif.pix_valid, 0);
    check("rst_pix_x", vif.pix_x, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_width", cfg_width, 0);
    check("rst_err", err_pulse, 0);
    check("rst_din_ready", vif.din_ready, 1);
    reset = 1'b1;
    settle(1);

    errs = 0;
    ctrl(16'd640, 16'd240, 4'hB);
    settle(3);
    check("t1_cfg_width", cfg_width, 640);
    check("t1_cfg_height", cfg_height, 240);
    check("t1_cfg_valid", cfg_valid, 1);
    check("t1_ctrl_err", errs, 0);
    video(641);
    settle(4);
    expect_pix("t1_vid", 641, 640, 1'b0);
    check("t1_early_eop_err", errs, 1);

    errs = 0;
    ctrl(16'd4, 16'd3, 4'hB);
    video(12);
    settle(4);
    expect_pix("t2_full", 12, 4, 1'b0);
    check("t2_err", errs, 0);

    ctrl(16'd4, 16'd3, 4'hF);
    video(12);
    settle(4);
    expect_pix("t3_field1", 12, 4, 1'b1);
    check("t3_err", errs, 0);

    video(15);
    settle(4);
    expect_pix("t4_excess", 12, 4, 1'b1);
    check("t4_excess_err", errs, 1);

    errs = 0;
    ctrl(16'd640, 16'd240, 4'hB);
    ctrl(16'h2D0, 16'd240, 4'hB);
    settle(3);
    check("t5_wide_err", errs, 1);
    check("t5_cfg_kept", cfg_width, 640);
    errs = 0;
    video(100);
    settle(4);
    expect_pix("t5_vid100", 100, 640, 1'b0);
    check("t5_vid_err", errs, 1);

    errs = 0;
    beat(8'h0F, 1'b1, 1'b0);
    beat(8'h50, 1'b0, 1'b0);
    beat(8'h52, 1'b0, 1'b0);
    beat(8'h58, 1'b0, 1'b1);
    settle(3);
    check("t6_short_err", errs, 1);
    check("t6_cfg_kept", cfg_width, 640);
    errs = 0;
    ctrl(16'd1, 16'd1, 4'h0);
    video(1);
    settle(4);
    check("t6_cfg_w1", cfg_width, 1);
    expect_pix("t6_1x1", 1, 1, 1'b0);
    check("t6_err", errs, 0);

    errs = 0;
    rdy_viol = 0;
    ctrl(16'd4, 16'd3, 4'hB);
    tog = 1'b1;
    video(12);
    settle(8);
    tog = 1'b0;
    settle(3);
    expect_pix("t7_toggle", 12, 4, 1'b0);
    check("t7_err", errs, 0);
    check("t7_ready_viol", rdy_viol, 0);

    errs = 0;
    beat(8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) beat(8'hAA, 1'b0, 1'b0);
    video(12);
    settle(4);
    check("t8_abort_err", errs, 1);
    check("t8_abort_count", got.size(), 15);
    got.delete();

    beat(8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) beat(8'h11, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("t9_rst_pix_valid", vif.pix_valid, 0);
    check("t9_rst_pix_x", vif.pix_x, 0);
    check("t9_rst_cfg_valid", cfg_valid, 0);
    check("t9_rst_cfg_width", cfg_width, 0);
    check("t9_rst_err", err_pulse, 0);
    reset = 1'b1;
    settle(1);
    got.delete();
    errs = 0;
    video(3);
    settle(4);
    check("t9_drain_pix", got.size(), 0);
    check("t9_drain_err", errs, 1);
    check("t9_pix_valid", vif.pix_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
